multdiv_ctrl: RTL
=================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 SHALL have port: data_operandA  in  32  signed multiplicand / dividend.
REQ-004 SHALL have port: data_operandB  in  32  signed multiplier / divisor.
REQ-005 SHALL have port: ctrl_MULT  in  1  single-cycle start pulse for multiply.
REQ-006 SHALL have port: ctrl_DIV  in  1  single-cycle start pulse for divide.
REQ-007 SHALL have port: data_result  out  32  signed result, registered.
REQ-008 SHALL have port: data_exception  out  1  overflow / divide-by-zero flag, qualified by data_resultRDY.
REQ-009 SHALL have port: data_resultRDY  out  1  one-cycle result-valid pulse; feeds the multdiv_RDY input of the pipeline stall logic.
REQ-010 SHALL have port: data_inputRDY  out  1  high when no operation is in flight.

Function
REQ-011 SHALL implement FSM states IDLE, MULT, DIV, DONE, held in registers.
REQ-012 In IDLE or DONE, a clock edge with ctrl_MULT=1 SHALL latch both operands, clear the 5-bit iteration counter to 0, and enter MULT.
REQ-013 In IDLE or DONE, a clock edge with ctrl_DIV=1 and ctrl_MULT=0 SHALL latch both operands, clear the counter, and enter DIV.
REQ-014 Simultaneous ctrl_MULT and ctrl_DIV SHALL start a multiply; ctrl_DIV is ignored.
REQ-015 In MULT/DIV, a start pulse SHALL abort the current operation and restart with the newly presented operands; no resultRDY is issued for the aborted operation.
REQ-016 MULT SHALL perform one shift-add step per cycle; DIV SHALL perform one restoring shift-subtract step per cycle on operand magnitudes. Both use exactly 32 iteration edges (counter 0..31).
REQ-017 On the iteration edge with counter=31, the FSM SHALL enter DONE and register data_result and data_exception.
REQ-018 data_resultRDY SHALL be high only in DONE, which lasts exactly one cycle before returning to IDLE, unless a start pulse is sampled.
REQ-019 Latency: if the capture edge is E0, data_resultRDY SHALL be high in the cycle after E32 and low again after E33.
REQ-020 Multiply result SHALL be the low 32 bits of the signed 64-bit product; data_exception=1 when product bits [63:31] are not all equal.
REQ-021 Divide result SHALL be the signed quotient truncated toward zero; the remainder is discarded.
REQ-022 Divide by zero SHALL take the full 32-cycle latency and produce result 32'h00000000 with data_exception=1.
REQ-023 Divide 32'h80000000 / 32'hFFFFFFFF SHALL produce result 32'h80000000 with data_exception=1.
REQ-024 data_result and data_exception SHALL hold their values from DONE until the next DONE or reset.
REQ-025 data_inputRDY SHALL be 1 in IDLE and DONE and 0 in MULT and DIV.
REQ-026 Operand inputs SHALL be ignored except on a capture edge; changes mid-operation do not affect the result.

Reset
REQ-027 With reset=1 at an edge, the block SHALL enter IDLE and set counter=0, data_result=0, data_exception=0, data_resultRDY=0, data_inputRDY=1.
REQ-028 Reset SHALL take priority over ctrl_MULT and ctrl_DIV at the same edge.
REQ-029 Reset mid-operation SHALL abort the operation with no resultRDY pulse.

Verification
REQ-030 ctrl_MULT pulse with A=7, B=-6 -> resultRDY high exactly in cycle E32–E33, result=0xFFFFFFD6, exception=0, inputRDY=0 during E1–E32.
REQ-031 ctrl_MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
REQ-032 ctrl_DIV with A=-7, B=2 -> result=0xFFFFFFFD, exception=0; ctrl_DIV with A=5, B=0 -> result=0, exception=1 after 32 cycles.
REQ-033 ctrl_DIV with A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
REQ-034 Start a multiply, then assert ctrl_DIV with A=100, B=7 at iteration 10 -> single resultRDY 32 cycles after the second pulse, result=14.
REQ-035 Assert reset at iteration 20 of a multiply -> no resultRDY, outputs zero, inputRDY=1; simultaneous ctrl_MULT and ctrl_DIV (A=3, B=4) -> result=12.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide controller. One shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle on operand magnitudes,
// 32 steps per operation, with sign fix-up and exception detection applied
// on the final step as the result is registered.
module multdiv_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        data_inputRDY
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMult = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // hi: upper product half (multiply) or partial remainder (divide).
  // lo: multiplier being consumed (multiply) or dividend/quotient (divide).
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // Magnitude of the multiplicand (multiply) or divisor (divide).
  logic [31:0] addend_q, addend_d;
  logic        neg_q, neg_d;
  logic        dz_q, dz_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] mult_sum;
  logic [31:0] mult_hi, mult_lo;
  logic [63:0] mult_prod, mult_prod_s;
  logic        mult_ovf;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] div_hi, div_lo, div_q_s;

  assign abs_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign abs_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // One unsigned shift-add step plus the signed view of the product it yields.
  always_comb begin
    mult_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : 33'd0);
    mult_hi     = mult_sum[32:1];
    mult_lo     = {mult_sum[0], lo_q[31:1]};
    mult_prod   = {mult_hi, mult_lo};
    mult_prod_s = neg_q ? (64'd0 - mult_prod) : mult_prod;
    // Result fits in 32 signed bits only if bits 63..31 are a pure sign extension.
    mult_ovf    = ~((&mult_prod_s[63:31]) | ~(|mult_prod_s[63:31]));
  end

  // One restoring shift-subtract step. The remainder stays below the divisor
  // (at most 2^31), so a 32-bit difference is exact whenever the subtract is kept.
  always_comb begin
    div_shift = {hi_q, lo_q[31]};
    div_ge    = div_shift >= {1'b0, addend_q};
    div_diff  = div_shift[31:0] - addend_q;
    div_hi    = div_ge ? div_diff : div_shift[31:0];
    div_lo    = {lo_q[30:0], div_ge};
    div_q_s   = neg_q ? (32'd0 - div_lo) : div_lo;
  end

  // Next-state: start pulses win in any state (restart/abort), else iterate.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    addend_d = addend_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (ctrl_MULT) begin
      state_d  = StMult;
      cnt_d    = 5'd0;
      hi_d     = 32'd0;
      lo_d     = abs_b;
      addend_d = abs_a;
      neg_d    = data_operandA[31] ^ data_operandB[31];
      dz_d     = 1'b0;
    end else if (ctrl_DIV) begin
      state_d  = StDiv;
      cnt_d    = 5'd0;
      hi_d     = 32'd0;
      lo_d     = abs_a;
      addend_d = abs_b;
      neg_d    = data_operandA[31] ^ data_operandB[31];
      dz_d     = (data_operandB == 32'd0);
    end else begin
      case (state_q)
        StMult: begin
          hi_d  = mult_hi;
          lo_d  = mult_lo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = StDone;
            result_d = mult_prod_s[31:0];
            exc_d    = mult_ovf;
          end
        end
        StDiv: begin
          hi_d  = div_hi;
          lo_d  = div_lo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StDone;
            if (dz_q) begin
              result_d = 32'd0;
              exc_d    = 1'b1;
            end else begin
              result_d = div_q_s;
              // Only |quotient| = 2^31 with a positive sign is unrepresentable.
              exc_d    = div_lo[31] & ~neg_q;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      addend_q <= 32'd0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      addend_q <= addend_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  // Handshake outputs are decoded straight from the state register.
  always_comb begin
    data_result    = result_q;
    data_exception = exc_q;
    data_resultRDY = (state_q == StDone);
    data_inputRDY  = (state_q == StIdle) || (state_q == StDone);
  end

endmodule
